pll_phase_step_ctl: RTL and testbench
=====================================

// Module: pll_phase_step_ctl
// PURPOSE
//  Sequencer for the ECP5 EHXPLLL dynamic phase-shift port. Turns "shift output N by K steps"
//  requests into timed PHASESEL/PHASEDIR/PHASESTEP waveforms. Supervises PLL LOCK: recovers a
//  lost lock by pulsing PLL RST and keeps a signed phase position per output.
//  Sits beside the board clock PLL; requesters are DDR/video calibration FSMs.
// PARAMETERS
//  SETUP_W  2      cycles PHASESEL/PHASEDIR are stable before the first PHASESTEP pulse
//  STEP_W   4      cycles PHASESTEP is held low per step
//  GAP_W    4      cycles PHASESTEP is held high between steps (and after the last step)
//  CNT_W    8      width of the step-count request field
//  POS_W    8      width of each per-output position counter (two's complement)
//  LOCK_TO  65535  cycles without lock in WAIT_LOCK before a PLL reset is issued
//  RST_W    16     cycles pll_rst is held high
// PORTS
//  clk              in   1        controller clock, free-running, not sourced from the PLL
//  rst_n            in   1        asynchronous active-low reset
//  req              in   1        request; sampled only in IDLE while locked=1
//  sel              in   2        output select: 0 CLKOS, 1 CLKOS2, 2 CLKOS3, 3 CLKOP
//  dir              in   1        0 = advance (pos +1/step), 1 = retard (pos -1/step)
//  steps            in   CNT_W    number of steps; 0 is legal
//  busy             out  1        high in every state except IDLE and WAIT_LOCK
//  done             out  1        one-cycle pulse at request completion or abort
//  err              out  1        sticky abort flag; cleared when the next request is accepted
//  locked           out  1        synchronised lock, low in RESET
//  pos              out  4*POS_W  phase positions; pos[i*POS_W +: POS_W] belongs to sel=i
//  pll_lock         in   1        EHXPLLL LOCK, asynchronous
//  pll_rst          out  1        EHXPLLL RST
//  pll_phasesel     out  2        EHXPLLL PHASESEL[1:0]
//  pll_phasedir     out  1        EHXPLLL PHASEDIR
//  pll_phasestep    out  1        EHXPLLL PHASESTEP, idle high
// BEHAVIOUR
//  - Reset values: state=WAIT_LOCK, pll_phasestep=1, pll_rst=0, pll_phasesel=0, pll_phasedir=0.
//    busy, done, err, locked and pos are all 0. All counters are 0.
//  - Lock path: pll_lock passes through a 2-FF synchroniser giving lock_s. locked = lock_s AND state!=RESET.
//  - States and transitions:
//    IDLE:      req & locked -> latch sel/dir/steps, clear err, go to SETUP.
//               lock_s=0 -> WAIT_LOCK.
//    SETUP:     pll_phasesel/pll_phasedir driven from the latched values for SETUP_W cycles.
//               Then go to PULSE, or go to DONE if steps==0 (no PHASESTEP activity).
//    PULSE:     pll_phasestep=0 for STEP_W cycles. On exit: pos[sel] += (dir ? -1 : +1), modulo 2^POS_W
//               (wraps, no saturation); remaining -= 1; go to GAP.
//    GAP:       pll_phasestep=1 for GAP_W cycles. Then PULSE if remaining!=0, else DONE.
//    DONE:      done=1 for one cycle, then IDLE. pll_phasesel/pll_phasedir hold their last values.
//    WAIT_LOCK: lock_s=1 -> IDLE and clear the timeout counter. Otherwise count; at LOCK_TO -> RESET.
//    RESET:     pll_rst=1 for RST_W cycles, all pos cleared to 0, then WAIT_LOCK with the counter cleared.
//  - Abort: lock_s=0 in SETUP, PULSE or GAP takes effect the next cycle:
//    pll_phasestep=1, err=1, done=1 (one cycle), state goes to WAIT_LOCK.
//    A PULSE that is cut short does NOT update pos.
//  - req is ignored outside IDLE. The requester holds req until done, then deasserts.
//    If req is still high in IDLE, a new request is accepted.
//  - Latency: accept cycle T, first PHASESTEP low at T+1+SETUP_W, done at T+1+SETUP_W+steps*(STEP_W+GAP_W).
//  - rst_n low at any time, including mid-pulse: all outputs return to their reset values
//    immediately (asynchronously); pll_phasestep goes high.
// TESTING
//  1. rst_n release with pll_lock=1 -> locked=1 by cycle 3. req sel=2 dir=0 steps=3 ->
//     phasesel=2 two cycles before the first low, 3 lows of 4 cycles separated by 4 highs, done at T+27, pos[2]=3.
//  2. steps=0, sel=1 -> no PHASESTEP activity, done at T+3, pos unchanged, busy low at T+4.
//  3. sel=0 dir=1 steps=5 from pos0=0 -> pos0=0xFB. Then two dir=0 steps=200 requests on sel=3 -> pos3=0x90 (wrap).
//  4. steps=4, drop pll_lock during the 2nd low pulse -> phasestep high within 3 cycles, err=1, done pulse,
//     pos[sel]=+1 only. The next accepted req clears err.
//  5. pll_lock held low: after LOCK_TO cycles pll_rst=1 for exactly 16 cycles and pos all 0.
//     Raise pll_lock -> locked=1, IDLE, a request completes normally.
//  6. Assert rst_n mid-PULSE -> phasestep=1 and busy=0 without a clock edge. Release -> WAIT_LOCK, pos=0.

Source files
------------

// File: rtl/pll_phase_step_ctl.sv
// Dynamic phase-shift sequencer for the ECP5 EHXPLLL: turns step requests into
// PHASESEL/PHASEDIR/PHASESTEP waveforms and supervises PLL lock with reset recovery.
module pll_phase_step_ctl #(
  parameter int SETUP_W = 2,
  parameter int STEP_W  = 4,
  parameter int GAP_W   = 4,
  parameter int CNT_W   = 8,
  parameter int POS_W   = 8,
  parameter int LOCK_TO = 65535,
  parameter int RST_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic [1:0]         sel,
  input  logic               dir,
  input  logic [CNT_W-1:0]   steps,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               locked,
  output logic [4*POS_W-1:0] pos,
  input  logic               pll_lock,
  output logic               pll_rst,
  output logic [1:0]         pll_phasesel,
  output logic               pll_phasedir,
  output logic               pll_phasestep
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_GAP, S_DONE, S_WAIT_LOCK, S_RESET
  } state_t;

  // One shared timer covers phase timing, reset width and the lock timeout.
  localparam int M0      = (SETUP_W > STEP_W) ? SETUP_W : STEP_W;
  localparam int M1      = (M0 > GAP_W) ? M0 : GAP_W;
  localparam int M2      = (M1 > RST_W) ? M1 : RST_W;
  localparam int TMR_MAX = (M2 > LOCK_TO) ? M2 : LOCK_TO;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic signed [POS_W-1:0] ONE = POS_W'(1);

  state_t                    state;
  logic                      sync1;
  logic                      lock_s;
  logic [TMR_W-1:0]          tmr;
  logic [CNT_W-1:0]          remaining;
  logic [1:0]                lat_sel;
  logic                      lat_dir;
  logic signed [POS_W-1:0]   pos_r [4];

  function automatic logic signed [POS_W-1:0] step_pos(
    input logic signed [POS_W-1:0] p,
    input logic                    d
  );
    return d ? (p - ONE) : (p + ONE);
  endfunction

  assign locked = lock_s & (state != S_RESET);

  for (genvar i = 0; i < 4; i++) begin : g_pos
    assign pos[i*POS_W +: POS_W] = pos_r[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_WAIT_LOCK;
      sync1         <= 1'b0;
      lock_s        <= 1'b0;
      tmr           <= '0;
      remaining     <= '0;
      lat_sel       <= '0;
      lat_dir       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      pll_rst       <= 1'b0;
      pll_phasesel  <= '0;
      pll_phasedir  <= 1'b0;
      pll_phasestep <= 1'b1;
      for (int i = 0; i < 4; i++) pos_r[i] <= '0;
    end else begin
      sync1  <= pll_lock;
      lock_s <= sync1;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!lock_s) begin
            state <= S_WAIT_LOCK;
            tmr   <= '0;
          end else if (req) begin
            lat_sel      <= sel;
            lat_dir      <= dir;
            remaining    <= steps;
            pll_phasesel <= sel;
            pll_phasedir <= dir;
            err          <= 1'b0;
            busy         <= 1'b1;
            tmr          <= '0;
            state        <= S_SETUP;
          end
        end
        S_SETUP, S_PULSE, S_GAP: begin
          // Lock loss beats any pending stage exit, so a truncated pulse never counts.
          if (!lock_s) begin
            state         <= S_WAIT_LOCK;
            tmr           <= '0;
            pll_phasestep <= 1'b1;
            err           <= 1'b1;
            done          <= 1'b1;
            busy          <= 1'b0;
          end else if (state == S_SETUP) begin
            if (tmr == TMR_W'(SETUP_W - 1)) begin
              tmr <= '0;
              if (remaining == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state         <= S_PULSE;
                pll_phasestep <= 1'b0;
              end
            end else begin
              tmr <= tmr + TMR_W'(1);
            end
          end else if (state == S_PULSE) begin
            if (tmr == TMR_W'(STEP_W - 1)) begin
              tmr              <= '0;
              pos_r[lat_sel]   <= step_pos(pos_r[lat_sel], lat_dir);
              remaining        <= remaining - CNT_W'(1);
              pll_phasestep    <= 1'b1;
              state            <= S_GAP;
            end else begin
              tmr <= tmr + TMR_W'(1);
            end
          end else begin
            if (tmr == TMR_W'(GAP_W - 1)) begin
              tmr <= '0;
              if (remaining != '0) begin
                state         <= S_PULSE;
                pll_phasestep <= 1'b0;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end else begin
              tmr <= tmr + TMR_W'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state <= S_IDLE;
            tmr   <= '0;
          end else if (tmr == TMR_W'(LOCK_TO - 1)) begin
            state   <= S_RESET;
            tmr     <= '0;
            pll_rst <= 1'b1;
            busy    <= 1'b1;
            for (int i = 0; i < 4; i++) pos_r[i] <= '0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        S_RESET: begin
          if (tmr == TMR_W'(RST_W - 1)) begin
            state   <= S_WAIT_LOCK;
            tmr     <= '0;
            pll_rst <= 1'b0;
            busy    <= 1'b0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        default: begin
          state <= S_WAIT_LOCK;
          tmr   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_phase_step_ctl.sv
// Directed and randomized checks of pll_phase_step_ctl against a cycle-level
// waveform/position model derived from the request rules.
module tb_pll_phase_step_ctl;
  localparam int LOCK_TO = 40;
  localparam int RST_W   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [1:0]  sel;
  logic        dir;
  logic [7:0]  steps;
  logic        busy, done, err, locked;
  logic [31:0] pos;
  logic        pll_lock;
  logic        pll_rst;
  logic [1:0]  pll_phasesel;
  logic        pll_phasedir;
  logic        pll_phasestep;

  int n_chk  = 0;
  int n_fail = 0;
  int pos_m [4];

  pll_phase_step_ctl #(
    .SETUP_W(2), .STEP_W(4), .GAP_W(4), .CNT_W(8), .POS_W(8),
    .LOCK_TO(LOCK_TO), .RST_W(RST_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .sel(sel), .dir(dir), .steps(steps),
    .busy(busy), .done(done), .err(err), .locked(locked), .pos(pos),
    .pll_lock(pll_lock), .pll_rst(pll_rst), .pll_phasesel(pll_phasesel),
    .pll_phasedir(pll_phasedir), .pll_phasestep(pll_phasestep)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pos_vec();
    logic [31:0] v;
    int          t;
    for (int i = 0; i < 4; i++) begin
      t = pos_m[i];
      v[i*8 +: 8] = t[7:0];
    end
    return v;
  endfunction

  function automatic void model_step(input int s, input int d, input int n);
    pos_m[s] = (((pos_m[s] + (d != 0 ? -n : n)) % 256) + 256) % 256;
  endfunction

  // Wait (bounded) until the controller is locked and idle.
  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 4 * LOCK_TO + 100; k++) begin
      @(negedge clk);
      if (locked === 1'b1 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    chk({tag, "_idle_reached"}, ok, 1'b1);
  endtask

  // Caller is at a negedge with the DUT in IDLE; the next edge accepts.
  task automatic run_req(input int s, input int d, input int n, input string tag);
    int  lat  = 0;
    int  werr = 0;
    bit  exp_low;
    req = 1'b1; sel = 2'(s); dir = d[0]; steps = 8'(n);
    for (int k = 1; k <= 3 + n * 8 + 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk({tag, "_phasesel"}, pll_phasesel, 64'(s));
        chk({tag, "_phasedir"}, pll_phasedir, 64'(d));
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_err_clr"}, err, 1'b0);
      end
      exp_low = (k >= 3) && ((k - 3) / 8 < n) && ((k - 3) % 8 < 4);
      if (pll_phasestep !== !exp_low) werr++;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    req = 1'b0;
    model_step(s, d, n);
    chk({tag, "_done_lat"}, 64'(lat), 64'(3 + n * 8));
    chk({tag, "_wave"}, 64'(werr), 64'd0);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 1'b0);
    chk({tag, "_done_1cyc"}, done, 1'b0);
    chk({tag, "_pos"}, pos, pos_vec());
  endtask

  initial begin
    int s, d, n, j, rise, hi;
    bit found;
    for (int i = 0; i < 4; i++) pos_m[i] = 0;
    rst_n = 1'b0; req = 1'b0; sel = '0; dir = 1'b0; steps = '0; pll_lock = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_phasestep", pll_phasestep, 1'b1);
    chk("rst_pll_rst", pll_rst, 1'b0);
    chk("rst_phasesel", pll_phasesel, 2'd0);
    chk("rst_flags", {busy, done, err, locked}, 4'b0000);
    chk("rst_pos", pos, 32'd0);

    // Test 1: lock after release, then a 3-step advance on output 2
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_locked_by_3", locked, 1'b1);
    run_req(2, 0, 3, "t1");

    // Test 2: zero-step request
    run_req(1, 0, 0, "t2");

    // Test 3: retard wrap below zero and advance wrap past 127
    run_req(0, 1, 5, "t3a");
    chk("t3_pos0_fb", pos[7:0], 8'hFB);
    run_req(3, 0, 200, "t3b");
    run_req(3, 0, 200, "t3c");
    chk("t3_pos3_90", pos[31:24], 8'h90);

    // Randomized requests
    for (int r = 0; r < 6; r++) begin
      s = $urandom_range(0, 3);
      d = $urandom_range(0, 1);
      n = $urandom_range(0, 12);
      run_req(s, d, n, $sformatf("rnd%0d", r));
    end

    // Test 4: lock drop during the second low pulse aborts the request
    req = 1'b1; sel = 2'd1; dir = 1'b0; steps = 8'd4;
    repeat (11) @(negedge clk);
    chk("t4_2nd_low", pll_phasestep, 1'b0);
    pll_lock = 1'b0;
    found = 1'b0; j = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found = 1'b1; j = k;
        break;
      end
    end
    req = 1'b0;
    chk("t4_abort_in_3", found && (j <= 3), 1'b1);
    chk("t4_phasestep_hi", pll_phasestep, 1'b1);
    chk("t4_err", err, 1'b1);
    chk("t4_busy", busy, 1'b0);
    model_step(1, 0, 1);
    @(negedge clk);
    chk("t4_done_1cyc", done, 1'b0);
    chk("t4_pos", pos, pos_vec());
    pll_lock = 1'b1;
    wait_idle("t4");
    chk("t4_err_sticky", err, 1'b1);
    run_req(2, 1, 2, "t4r");

    // Test 5: lock timeout issues a PLL reset and clears positions
    pll_lock = 1'b0;
    rise = 0;
    for (int k = 1; k <= LOCK_TO + 30; k++) begin
      @(negedge clk);
      if (pll_rst === 1'b1) begin
        rise = k;
        break;
      end
    end
    chk("t5_rise_window", (rise >= LOCK_TO + 1) && (rise <= LOCK_TO + 4), 1'b1);
    chk("t5_locked_low", locked, 1'b0);
    chk("t5_busy_rst", busy, 1'b1);
    chk("t5_pos_clr", pos, 32'd0);
    hi = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pll_rst === 1'b1) hi++;
      else break;
    end
    chk("t5_rst_width", 64'(hi), 64'(RST_W));
    for (int i = 0; i < 4; i++) pos_m[i] = 0;
    pll_lock = 1'b1;
    wait_idle("t5");
    run_req(0, 0, 2, "t5r");

    // Test 6: asynchronous reset in the middle of a pulse
    req = 1'b1; sel = 2'd0; dir = 1'b0; steps = 8'd3;
    repeat (3) @(negedge clk);
    chk("t6_low_before", pll_phasestep, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_phasestep", pll_phasestep, 1'b1);
    chk("t6_async_busy", busy, 1'b0);
    chk("t6_async_pos", pos, 32'd0);
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) pos_m[i] = 0;
    chk("t6_locked_after", locked, 1'b0);
    wait_idle("t6");
    run_req(3, 1, 1, "t6r");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
